ihp_sram_fabric_responder: RTL and testbench

- Responder end of the fabric-to-SRAM access interface in the IHP SRAM column.
- Fabric logic (the initiator) routes requests in through the terminal tile. This block accepts one request at a time and sequences the IHP single-port SRAM macro pins (A_*).
- It returns the read data or a write acknowledge over a valid/ready response channel.
- After reset it can optionally sweep the whole macro and write it to zero before accepting traffic.

---
 rtl/ihp_sram_fabric_responder.sv | 177 +++++++++++++++++
 tb/tb_ihp_sram_fabric_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ihp_sram_fabric_responder.sv
// Responder for fabric-initiated accesses to an IHP single-port SRAM macro.
// One request in flight; optional post-reset zero-fill sweep of the whole macro.
module ihp_sram_fabric_responder #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic              UserCLK,
  input  logic              UserRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_bmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy,
  output logic              A_MEN,
  output logic              A_WEN,
  output logic              A_REN,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DIN,
  output logic [DATA_W-1:0] A_BM,
  input  logic [DATA_W-1:0] A_DOUT
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              init_busy_q, init_busy_d;
  logic              a_men_q, a_men_d;
  logic              a_wen_q, a_wen_d;
  logic              a_ren_q, a_ren_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_din_q, a_din_d;
  logic [DATA_W-1:0] a_bm_q, a_bm_d;

  // Outputs are registered with the value belonging to the state being entered,
  // so each state's pin pattern is visible for exactly the cycle spent in it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    init_busy_d = init_busy_q;
    a_men_d     = 1'b0;
    a_wen_d     = 1'b0;
    a_ren_d     = 1'b0;
    a_addr_d    = '0;
    a_din_d     = '0;
    a_bm_d      = '0;

    unique case (state_q)
      S_INIT: begin
        if (cnt_q[ADDR_W]) begin
          state_d     = S_IDLE;
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          a_men_d  = 1'b1;
          a_wen_d  = 1'b1;
          a_bm_d   = '1;
          a_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = S_ACCESS;
          req_ready_d = 1'b0;
          we_d        = req_we;
          a_men_d     = 1'b1;
          a_wen_d     = req_we;
          a_ren_d     = !req_we;
          a_addr_d    = req_addr;
          if (req_we) begin
            a_din_d = req_wdata;
            a_bm_d  = req_bmask;
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Macro read edge was the one entering this state; A_DOUT is valid now.
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = A_DOUT;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      state_q     <= (INIT_CLEAR != 0) ? S_INIT : S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      init_busy_q <= (INIT_CLEAR != 0);
      a_men_q     <= 1'b0;
      a_wen_q     <= 1'b0;
      a_ren_q     <= 1'b0;
      a_addr_q    <= '0;
      a_din_q     <= '0;
      a_bm_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_busy_q <= init_busy_d;
      a_men_q     <= a_men_d;
      a_wen_q     <= a_wen_d;
      a_ren_q     <= a_ren_d;
      a_addr_q    <= a_addr_d;
      a_din_q     <= a_din_d;
      a_bm_q      <= a_bm_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_busy = init_busy_q;
  assign A_MEN     = a_men_q;
  assign A_WEN     = a_wen_q;
  assign A_REN     = a_ren_q;
  assign A_ADDR    = a_addr_q;
  assign A_DIN     = a_din_q;
  assign A_BM      = a_bm_q;

endmodule

// File: tb/tb_ihp_sram_fabric_responder.sv
// Bench for ihp_sram_fabric_responder: directed table, reset corner cases and
// randomized transactions against a transaction-level memory model.
module tb_ihp_sram_fabric_responder;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          UserCLK = 1'b0;
  logic          UserRST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_bmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
  logic          A_MEN, A_WEN, A_REN;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_DIN, A_BM;
  logic [DW-1:0] A_DOUT = '0;

  always #5 UserCLK = ~UserCLK;

  ihp_sram_fabric_responder #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1)) dut (
    .UserCLK(UserCLK), .UserRST(UserRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .init_busy(init_busy),
    .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN), .A_ADDR(A_ADDR),
    .A_DIN(A_DIN), .A_BM(A_BM), .A_DOUT(A_DOUT)
  );

  // Pin-level SRAM macro: read data appears the cycle after the read edge.
  logic [DW-1:0] mem [DEPTH];
  logic          preload = 1'b0;
  always @(posedge UserCLK) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else begin
      if (A_MEN && A_WEN) mem[A_ADDR] <= (mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
      if (A_MEN && A_REN) A_DOUT <= mem[A_ADDR];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bmask;
    int            hold;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the negedge where reset has just been released.
  task automatic check_sweep(input string tag);
    int nbusy = 0;
    int nok = 0;
    int c = 0;
    logic [31:0] exp_a = 0;
    logic fell = 1'b0;
    while (c < 40 && !fell) begin
      @(negedge UserCLK);
      c++;
      if (init_busy) begin
        nbusy++;
        if (A_MEN && A_WEN && !A_REN && A_DIN == '0 && A_BM == '1 &&
            32'(A_ADDR) == exp_a && !req_ready && !rsp_valid) nok++;
        exp_a++;
      end else begin
        fell = 1'b1;
        chk({tag, " ready_at_fall"}, 32'(req_ready), 1);
        chk({tag, " strobes_at_fall"}, {A_MEN, A_WEN, A_REN}, 0);
      end
    end
    chk({tag, " busy_fell"}, 32'(fell), 1);
    chk({tag, " busy_cycles"}, nbusy, DEPTH);
    chk({tag, " sweep_beats"}, nok, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW-1:0] bm, input int hold,
                     output logic [DW-1:0] rd, output logic rwe, output int lat,
                     output int nmen, output int nwen, output int nren,
                     output logic [AW-1:0] sa, output logic [DW-1:0] sdin,
                     output logic [DW-1:0] sbm, output int viol);
    int t = 0;
    int c = 1;
    lat = 0; nmen = 0; nwen = 0; nren = 0; viol = 0;
    sa = '0; sdin = '0; sbm = '0;
    while (!req_ready && t < 50) begin
      @(negedge UserCLK);
      t++;
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_bmask = bm;
    rsp_ready = 1'b0;
    @(negedge UserCLK);
    // Junk request kept valid while busy: must be ignored.
    req_we = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = $urandom; req_bmask = $urandom;
    while (c <= 40) begin
      if (A_MEN) begin nmen++; sa = A_ADDR; sdin = A_DIN; sbm = A_BM; end
      if (A_WEN) nwen++;
      if (A_REN) nren++;
      if (A_WEN && A_REN) viol++;
      if (req_ready) viol++;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(negedge UserCLK);
      c++;
    end
    rd = rsp_rdata;
    rwe = rsp_we;
    for (int h = 0; h < hold; h++) begin
      @(negedge UserCLK);
      if (!rsp_valid || rsp_rdata !== rd || rsp_we !== rwe || req_ready ||
          A_MEN || A_WEN || A_REN) viol++;
    end
    rsp_ready = 1'b1;
    @(negedge UserCLK);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (rsp_valid || !req_ready) viol++;
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] bm,
                         input int hold, input logic [DW-1:0] exp_rd);
    logic [DW-1:0] rd, sdin, sbm;
    logic rwe;
    logic [AW-1:0] sa;
    int lat, nmen, nwen, nren, viol;
    txn(we, a, wd, bm, hold, rd, rwe, lat, nmen, nwen, nren, sa, sdin, sbm, viol);
    chk({nm, " latency"}, lat, we ? 2 : 3);
    chk({nm, " men_cycles"}, nmen, 1);
    chk({nm, " wen_cycles"}, nwen, we ? 1 : 0);
    chk({nm, " ren_cycles"}, nren, we ? 0 : 1);
    chk({nm, " a_addr"}, 32'(sa), 32'(a));
    chk({nm, " a_din"}, sdin, we ? wd : '0);
    chk({nm, " a_bm"}, sbm, we ? bm : '0);
    chk({nm, " rsp_we"}, 32'(rwe), 32'(we));
    chk({nm, " rsp_rdata"}, rd, exp_rd);
    chk({nm, " protocol"}, viol, 0);
    if (we) ref_mem[a] = (ref_mem[a] & ~bm) | (wd & bm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    tbl[0] = '{1'b1, 4'h5, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'h0};
    tbl[1] = '{1'b0, 4'h5, 32'h0,        32'h0,        0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 4'h5, 32'h12345678, 32'h0000FFFF, 1, 32'h0};
    tbl[3] = '{1'b0, 4'h5, 32'h0,        32'h0,        5, 32'hDEAD5678};
    tbl[4] = '{1'b0, 4'h9, 32'h0,        32'h0,        0, 32'h0};
    tbl[5] = '{1'b1, 4'hF, 32'hA5A5A5A5, 32'hFFFFFFFF, 2, 32'h0};
    tbl[6] = '{1'b0, 4'hF, 32'h0,        32'h0,        0, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 4'h0, 32'hFFFFFFFF, 32'hF0F0F0F0, 0, 32'h0};
    tbl[8] = '{1'b0, 4'h0, 32'h0,        32'h0,        3, 32'hF0F0F0F0};

    preload = 1'b1;
    UserRST = 1'b1;
    repeat (3) @(negedge UserCLK);
    preload = 1'b0;
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst strobes", {A_MEN, A_WEN, A_REN}, 0);
    chk("rst a_addr", 32'(A_ADDR), 0);
    chk("rst a_din", A_DIN, 0);
    chk("rst a_bm", A_BM, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst init_busy", 32'(init_busy), 1);
    UserRST = 1'b0;
    check_sweep("init");

    // Reset mid-sweep at address 7; sweep must restart from 0.
    UserRST = 1'b1;
    @(negedge UserCLK);
    UserRST = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge UserCLK);
      if (A_WEN && A_ADDR == 4'd7) found = 1;
    end
    chk("midsweep reached7", found, 1);
    UserRST = 1'b1;
    @(negedge UserCLK);
    chk("midsweep strobes", {A_MEN, A_WEN, A_REN}, 0);
    chk("midsweep rsp_valid", 32'(rsp_valid), 0);
    chk("midsweep busy", 32'(init_busy), 1);
    UserRST = 1'b0;
    check_sweep("resweep");

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].bmask, tbl[i].hold, tbl[i].exp_rdata);

    for (int i = 0; i < 30; i++) begin
      logic we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, bm;
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom);
      wd = $urandom;
      bm = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
      run_txn($sformatf("rnd%0d", i), we, a, wd, bm, $urandom_range(0, 3),
              we ? '0 : ref_mem[a]);
    end

    // Reset while the macro access is on the pins; the request must vanish.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3;
    @(negedge UserCLK);
    chk("acc_rst access_seen", 32'(A_REN), 1);
    UserRST = 1'b1;
    req_valid = 1'b0;
    @(negedge UserCLK);
    chk("acc_rst strobes", {A_MEN, A_WEN, A_REN}, 0);
    chk("acc_rst rsp_valid", 32'(rsp_valid), 0);
    chk("acc_rst req_ready", 32'(req_ready), 0);
    UserRST = 1'b0;
    check_sweep("acc_rst");
    run_txn("after_rst_read", 1'b0, 4'h3, '0, '0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
